// File: rtl/demuxer4_guard.sv
// demuxer4_guard: registered 1-to-16 sample demultiplexer with a
// break-before-make guard interval on every route change and a saturating
// count of samples dropped while the route is changing.
// Optional build macro: DEMUXER4_ZERO_IDLE_EN (idle channels read 0 instead
// of holding their last written value).
//
// state    | meaning
// ST_RUN   | routing samples to active_sel
// ST_GUARD | route changing, no channel written, counting guard cycles
module demuxer4_guard #(
  parameter int RES   = 14,
  parameter int GUARD = 4
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [3:0]     sel,
  input  logic [RES-1:0] in,
  input  logic           in_valid,
  input  logic           drop_clr,
  output logic [RES-1:0] out0,
  output logic [RES-1:0] out1,
  output logic [RES-1:0] out2,
  output logic [RES-1:0] out3,
  output logic [RES-1:0] out4,
  output logic [RES-1:0] out5,
  output logic [RES-1:0] out6,
  output logic [RES-1:0] out7,
  output logic [RES-1:0] out8,
  output logic [RES-1:0] out9,
  output logic [RES-1:0] out10,
  output logic [RES-1:0] out11,
  output logic [RES-1:0] out12,
  output logic [RES-1:0] out13,
  output logic [RES-1:0] out14,
  output logic [RES-1:0] out15,
  output logic [15:0]    out_vld,
  output logic [3:0]     active_sel,
  output logic           busy,
  output logic [15:0]    drop_cnt
);

  localparam logic [7:0] GLAST = 8'(GUARD - 1);

  typedef enum logic {ST_RUN, ST_GUARD} state_t;

  state_t         state;
  logic [3:0]     pending;
  logic [7:0]     cnt;
  logic [RES-1:0] chan [16];
  logic           drop;

  assign out0  = chan[0];
  assign out1  = chan[1];
  assign out2  = chan[2];
  assign out3  = chan[3];
  assign out4  = chan[4];
  assign out5  = chan[5];
  assign out6  = chan[6];
  assign out7  = chan[7];
  assign out8  = chan[8];
  assign out9  = chan[9];
  assign out10 = chan[10];
  assign out11 = chan[11];
  assign out12 = chan[12];
  assign out13 = chan[13];
  assign out14 = chan[14];
  assign out15 = chan[15];

  // A sample is lost whenever the route is not settled on the requested channel.
  assign drop = in_valid && ((state == ST_GUARD) || (sel != active_sel));

  // Route FSM, channel registers and write strobes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_RUN;
      pending    <= 4'd0;
      cnt        <= 8'd0;
      active_sel <= 4'd0;
      busy       <= 1'b0;
      out_vld    <= 16'd0;
      for (int i = 0; i < 16; i++) chan[i] <= '0;
    end else begin
      out_vld <= 16'd0;
      case (state)
        ST_RUN: begin
          if (sel == active_sel) begin
`ifdef DEMUXER4_ZERO_IDLE_EN
            for (int i = 0; i < 16; i++)
              if (i != int'(active_sel)) chan[i] <= '0;
`endif
            if (in_valid) begin
              chan[active_sel]    <= in;
              out_vld[active_sel] <= 1'b1;
            end
          end else begin
            state   <= ST_GUARD;
            pending <= sel;
            cnt     <= 8'd0;
            busy    <= 1'b1;
`ifdef DEMUXER4_ZERO_IDLE_EN
            // Blank on entry so every channel already reads 0 while busy is high.
            for (int i = 0; i < 16; i++) chan[i] <= '0;
`endif
          end
        end
        default: begin
`ifdef DEMUXER4_ZERO_IDLE_EN
          for (int i = 0; i < 16; i++) chan[i] <= '0;
`endif
          if (sel != pending) begin
            pending <= sel;
            cnt     <= 8'd0;
          end else if (cnt == GLAST) begin
            active_sel <= pending;
            state      <= ST_RUN;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

  // Saturating drop counter; clear has priority over a same-cycle drop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_cnt <= 16'd0;
    end else if (drop_clr) begin
      drop_cnt <= 16'd0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_demuxer4_guard.sv
// Directed testbench for demuxer4_guard (RES = 14, GUARD = 4).
module tb_demuxer4_guard;

  localparam int RES = 14;

  logic           clk_i = 1'b0;
  logic           rstn_i = 1'b0;
  logic [3:0]     sel = 4'd0;
  logic [RES-1:0] in = '0;
  logic           in_valid = 1'b0;
  logic           drop_clr = 1'b0;
  logic [RES-1:0] outs [16];
  logic [15:0]    out_vld;
  logic [3:0]     active_sel;
  logic           busy;
  logic [15:0]    drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  demuxer4_guard #(.RES(RES), .GUARD(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .sel(sel), .in(in), .in_valid(in_valid),
    .drop_clr(drop_clr),
    .out0(outs[0]),   .out1(outs[1]),   .out2(outs[2]),   .out3(outs[3]),
    .out4(outs[4]),   .out5(outs[5]),   .out6(outs[6]),   .out7(outs[7]),
    .out8(outs[8]),   .out9(outs[9]),   .out10(outs[10]), .out11(outs[11]),
    .out12(outs[12]), .out13(outs[13]), .out14(outs[14]), .out15(outs[15]),
    .out_vld(out_vld), .active_sel(active_sel), .busy(busy), .drop_cnt(drop_cnt)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #3;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (outs[i] !== '0) begin
        $display("FAIL reset_out%0d got %h exp 0", i, outs[i]); n_fail++;
      end
    end
    n_checks++;
    if ({out_vld, active_sel, busy, drop_cnt} !== 37'd0) begin
      $display("FAIL reset_ctrl vld=%h act=%h busy=%b drop=%h exp all 0",
               out_vld, active_sel, busy, drop_cnt); n_fail++;
    end
    tick();
    rstn_i = 1'b1;
  endtask

  task automatic test_route();
    sel = 4'd0; in = 14'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (outs[0] !== 14'h1234 || out_vld !== 16'h0001) begin
      $display("FAIL route_first out0=%h vld=%h exp 1234/0001", outs[0], out_vld); n_fail++;
    end
    tick();
    n_checks++;
    if (out_vld !== 16'h0000 || outs[0] !== 14'h1234) begin
      $display("FAIL route_oneshot out0=%h vld=%h exp 1234/0000", outs[0], out_vld); n_fail++;
    end
    for (int i = 1; i < 16; i++) begin
      n_checks++;
      if (outs[i] !== '0) begin
        $display("FAIL route_other%0d got %h exp 0", i, outs[i]); n_fail++;
      end
    end
  endtask

  task automatic test_guard();
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    sel = 4'd5; in = 14'h0AAA; in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) in = 14'h0BBB;
      tick();
      n_checks++;
      if (busy !== (k <= 4) || active_sel !== ((k <= 4) ? 4'd0 : 4'd5) ||
          out_vld !== 16'd0 || outs[5] !== '0) begin
        $display("FAIL guard_step%0d busy=%b act=%0d vld=%h out5=%h exp busy=%b act=%0d vld=0 out5=0",
                 k, busy, active_sel, out_vld, outs[5], (k <= 4), (k <= 4) ? 0 : 5); n_fail++;
      end
    end
    n_checks++;
    if (drop_cnt !== 16'd5) begin
      $display("FAIL guard_drops got %0d exp 5", drop_cnt); n_fail++;
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (outs[5] !== 14'h0BBB || out_vld !== 16'h0020 || drop_cnt !== 16'd5) begin
      $display("FAIL guard_first_sample out5=%h vld=%h drop=%0d exp 0bbb/0020/5",
               outs[5], out_vld, drop_cnt); n_fail++;
    end
  endtask

  task automatic test_restart();
    sel = 4'd9; in = 14'h0111; in_valid = 1'b1;
    tick();
    tick();
    sel = 4'd7;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (active_sel !== ((k < 4) ? 4'd5 : 4'd7) || busy !== (k < 4) ||
          out_vld !== 16'd0 || outs[9] !== '0) begin
        $display("FAIL restart_step%0d act=%0d busy=%b vld=%h out9=%h exp act=%0d busy=%b vld=0 out9=0",
                 k, active_sel, busy, out_vld, outs[9], (k < 4) ? 5 : 7, (k < 4)); n_fail++;
      end
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (outs[7] !== 14'h0111 || out_vld !== 16'h0080 || outs[9] !== '0) begin
      $display("FAIL restart_route out7=%h vld=%h out9=%h exp 0111/0080/0", outs[7], out_vld, outs[9]); n_fail++;
    end
  endtask

  task automatic test_idle();
    logic [RES-1:0] exp0;
`ifdef DEMUXER4_ZERO_IDLE_EN
    exp0 = '0;
`else
    exp0 = 14'h1234;
`endif
    sel = 4'd0;
    for (int k = 0; k < 5; k++) tick();
    in = 14'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (outs[0] !== 14'h1234) begin
      $display("FAIL idle_load out0=%h exp 1234", outs[0]); n_fail++;
    end
    sel = 4'd3;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (outs[0] !== exp0) begin
        $display("FAIL idle_hold_step%0d out0=%h exp %h", k, outs[0], exp0); n_fail++;
      end
    end
    n_checks++;
    if (active_sel !== 4'd3 || outs[3] !== '0) begin
      $display("FAIL idle_newchan act=%0d out3=%h exp 3/0", active_sel, outs[3]); n_fail++;
    end
  endtask

  task automatic test_drop_sat();
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 65534; k++) begin
      sel = (k % 2 == 0) ? 4'd1 : 4'd2;
      tick();
    end
    n_checks++;
    if (drop_cnt !== 16'hFFFE) begin
      $display("FAIL drop_count got %h exp fffe", drop_cnt); n_fail++;
    end
    for (int k = 0; k < 10; k++) begin
      sel = (k % 2 == 0) ? 4'd1 : 4'd2;
      tick();
    end
    n_checks++;
    if (drop_cnt !== 16'hFFFF) begin
      $display("FAIL drop_saturate got %h exp ffff", drop_cnt); n_fail++;
    end
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    n_checks++;
    if (drop_cnt !== 16'h0000) begin
      $display("FAIL drop_clr_wins got %h exp 0000", drop_cnt); n_fail++;
    end
    tick();
    n_checks++;
    if (drop_cnt !== 16'h0001) begin
      $display("FAIL drop_after_clr got %h exp 0001", drop_cnt); n_fail++;
    end
    in_valid = 1'b0;
    sel = 4'd0;
    for (int k = 0; k < 8; k++) tick();
    n_checks++;
    if (active_sel !== 4'd0 || busy !== 1'b0) begin
      $display("FAIL drop_settle act=%0d busy=%b exp 0/0", active_sel, busy); n_fail++;
    end
  endtask

  task automatic test_async_reset();
    sel = 4'd6; in_valid = 1'b1; in = 14'h0555;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      $display("FAIL areset_pre busy=%b exp 1", busy); n_fail++;
    end
    #2;
    rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({out_vld, active_sel, busy, drop_cnt} !== 37'd0) begin
      $display("FAIL areset_ctrl vld=%h act=%h busy=%b drop=%h exp all 0",
               out_vld, active_sel, busy, drop_cnt); n_fail++;
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (outs[i] !== '0) begin
        $display("FAIL areset_out%0d got %h exp 0", i, outs[i]); n_fail++;
      end
    end
    rstn_i = 1'b1;
    sel = 4'd0; in = 14'h2222; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (outs[0] !== 14'h2222 || out_vld !== 16'h0001 || busy !== 1'b0) begin
      $display("FAIL areset_route out0=%h vld=%h busy=%b exp 2222/0001/0", outs[0], out_vld, busy); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_route();
    test_guard();
    test_restart();
    test_idle();
    test_drop_sat();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
